// File: rtl/sdspi_card_responder_if.sv
// SPI link plus block-memory port of the SD card responder.
//   slave  : the card side (sdspi_card_responder)
//   master : the host/memory side (testbench or SoC wrapper)
// Signals: cs/sclk/mosi/miso = SPI mode-0 link; blk_addr/byte_idx/mem_* =
// byte-wide block memory; debug = status word.
interface sdspi_card_responder_if;
  logic        cs;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [31:0] blk_addr;
  logic [8:0]  byte_idx;
  logic [7:0]  mem_rd_data;
  logic        mem_we;
  logic [7:0]  mem_wr_data;
  logic [31:0] debug;

  modport slave (
    input  cs, sclk, mosi, mem_rd_data,
    output miso, blk_addr, byte_idx, mem_we, mem_wr_data, debug
  );

  modport master (
    output cs, sclk, mosi, mem_rd_data,
    input  miso, blk_addr, byte_idx, mem_we, mem_wr_data, debug
  );
endinterface

// File: rtl/sdspi_card_responder.sv
// SPI-mode SD card target. Decodes 6-byte commands on mosi and answers with
// R1, single-block read streams and write responses on miso. Block payloads
// come from / go to an external byte-wide memory.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - SPI link (cs/sclk/mosi/miso), memory port (blk_addr, byte_idx,
//          mem_rd_data, mem_we, mem_wr_data) and debug status word
module sdspi_card_responder #(
  parameter int NCR_BYTES   = 1,
  parameter int NAC_BYTES   = 2,
  parameter int BUSY_BYTES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sdspi_card_responder_if.slave  bus
);

  typedef enum logic [3:0] {
    CMD_WAIT, CMD_RX, NCR, R1, RD_NAC, RD_TOKEN, RD_DATA, RD_CRC,
    WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
  } state_e;

  // {cs, sclk, mosi} synchronizer chain
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [SYNC_STAGES:0][2:0]   sync_ext;
  logic cs_s, sclk_s, mosi_s;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_rise, sclk_fall, cs_fall, byte_done;

  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d;
  logic [31:0] blk_addr_q, blk_addr_d;
  logic [7:0]  r1_q, r1_d;
  logic        idle_q, idle_d;
  logic        app_q, app_d;
  logic [8:0]  byte_idx_q, byte_idx_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_wr_data_q, mem_wr_data_d;

  logic [7:0]  r1_dec;
  logic        idle_dec, ld_addr;

  always_comb begin
    sync_ext = {sync_q, bus.cs, bus.sclk, bus.mosi};
    sync_d   = sync_ext[SYNC_STAGES-1:0];
  end

  assign {cs_s, sclk_s, mosi_s} = sync_q[SYNC_STAGES-1];
  assign sclk_rise = ~cs_s &  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~cs_s & ~sclk_s &  sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);
  // Full received byte, valid in the byte_done cycle
  assign rx_byte   = {rx_shift_q, mosi_s};

  // Bit engine. Falling edge n (1..7) drives bit 7-n; after the 8th rising
  // edge bit_cnt has wrapped to 0, so the same index picks bit 7 of the
  // freshly loaded tx byte.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    miso_d     = miso_q;
    if (cs_s) begin
      bit_cnt_d = 3'd0;
      miso_d    = 1'b1;
    end else begin
      if (cs_fall) miso_d = tx_q[7];
      if (sclk_rise) begin
        bit_cnt_d  = bit_cnt_q + 3'd1;
        rx_shift_d = rx_byte[6:0];
      end
      if (sclk_fall) miso_d = tx_q[~bit_cnt_q];
    end
  end

  // R1 / side effects for the latched command, applied when R1 is queued
  always_comb begin
    r1_dec   = 8'h04 | {7'b0, idle_q};
    idle_dec = idle_q;
    ld_addr  = 1'b0;
    case (cmd_q)
      6'd0:  begin idle_dec = 1'b1; r1_dec = 8'h01; end
      6'd1:  begin idle_dec = 1'b0; r1_dec = 8'h00; end
      6'd41: if (app_q) begin idle_dec = 1'b0; r1_dec = 8'h00; end
      6'd8, 6'd16, 6'd55: r1_dec = {7'b0, idle_q};
      6'd17, 6'd24: begin
        if (idle_q) r1_dec = 8'h01;
        else begin r1_dec = 8'h00; ld_addr = 1'b1; end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    tx_d          = tx_q;
    cnt_d         = cnt_q;
    cmd_d         = cmd_q;
    arg_d         = arg_q;
    blk_addr_d    = blk_addr_q;
    r1_d          = r1_q;
    idle_d        = idle_q;
    app_d         = app_q;
    mem_we_d      = 1'b0;
    mem_wr_data_d = mem_wr_data_q;
    // Write address advances the cycle after the strobe so mem_we sees the
    // current index.
    byte_idx_d    = mem_we_q ? byte_idx_q + 9'd1 : byte_idx_q;
    if (byte_done) begin
      tx_d = 8'hFF;
      case (state_q)
        CMD_WAIT: if (rx_byte[7:6] == 2'b01) begin
          cmd_d   = rx_byte[5:0];
          cnt_d   = 9'd0;
          state_d = CMD_RX;
        end
        CMD_RX: begin
          // 4 argument bytes then the (ignored) CRC byte
          if (cnt_q != 9'd4) arg_d = {arg_q[23:0], rx_byte};
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == 9'd4) begin state_d = NCR; cnt_d = 9'd0; end
        end
        NCR: begin
          if (cnt_q == 9'(NCR_BYTES-1)) begin
            state_d = R1;
            tx_d    = r1_dec;
            r1_d    = r1_dec;
            idle_d  = idle_dec;
            app_d   = (cmd_q == 6'd55);
            if (ld_addr) blk_addr_d = arg_q;
          end else cnt_d = cnt_q + 9'd1;
        end
        R1: begin
          cnt_d = 9'd0;
          if (cmd_q == 6'd17 && !idle_q) begin
            state_d    = RD_NAC;
            byte_idx_d = 9'd0;
          end else if (cmd_q == 6'd24 && !idle_q) state_d = WR_TOKEN;
          else state_d = CMD_WAIT;
        end
        RD_NAC: begin
          if (cnt_q == 9'(NAC_BYTES-1)) begin state_d = RD_TOKEN; tx_d = 8'hFE; end
          else cnt_d = cnt_q + 9'd1;
        end
        RD_TOKEN: begin
          state_d    = RD_DATA;
          tx_d       = bus.mem_rd_data;
          byte_idx_d = byte_idx_q + 9'd1;
          cnt_d      = 9'd0;
        end
        RD_DATA: begin
          if (cnt_q == 9'd511) begin
            state_d = RD_CRC; tx_d = 8'h00; cnt_d = 9'd0;
          end else begin
            tx_d       = bus.mem_rd_data;
            byte_idx_d = byte_idx_q + 9'd1;
            cnt_d      = cnt_q + 9'd1;
          end
        end
        RD_CRC: begin
          if (cnt_q == 9'd1) state_d = CMD_WAIT;
          else begin tx_d = 8'h00; cnt_d = 9'd1; end
        end
        WR_TOKEN: if (rx_byte == 8'hFE) begin
          state_d    = WR_DATA;
          byte_idx_d = 9'd0;
          cnt_d      = 9'd0;
        end
        WR_DATA: begin
          mem_we_d      = 1'b1;
          mem_wr_data_d = rx_byte;
          cnt_d         = cnt_q + 9'd1;
          if (cnt_q == 9'd511) begin state_d = WR_CRC; cnt_d = 9'd0; end
        end
        WR_CRC: begin
          if (cnt_q == 9'd1) begin state_d = WR_RESP; tx_d = 8'h05; end
          else cnt_d = 9'd1;
        end
        WR_RESP: begin state_d = WR_BUSY; tx_d = 8'h00; cnt_d = 9'd0; end
        WR_BUSY: begin
          if (cnt_q == 9'(BUSY_BYTES-1)) state_d = CMD_WAIT;
          else begin tx_d = 8'h00; cnt_d = cnt_q + 9'd1; end
        end
        default: state_d = CMD_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q        <= {SYNC_STAGES{3'b101}};
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b1;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 7'd0;
      tx_q          <= 8'hFF;
      miso_q        <= 1'b1;
      state_q       <= CMD_WAIT;
      cnt_q         <= 9'd0;
      cmd_q         <= 6'd0;
      arg_q         <= 32'd0;
      blk_addr_q    <= 32'd0;
      r1_q          <= 8'd0;
      idle_q        <= 1'b1;
      app_q         <= 1'b0;
      byte_idx_q    <= 9'd0;
      mem_we_q      <= 1'b0;
      mem_wr_data_q <= 8'd0;
    end else begin
      sync_q        <= sync_d;
      sclk_prev_q   <= sclk_s;
      cs_prev_q     <= cs_s;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_q          <= tx_d;
      miso_q        <= miso_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      arg_q         <= arg_d;
      blk_addr_q    <= blk_addr_d;
      r1_q          <= r1_d;
      idle_q        <= idle_d;
      app_q         <= app_d;
      byte_idx_q    <= byte_idx_d;
      mem_we_q      <= mem_we_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign bus.miso        = miso_q;
  assign bus.blk_addr    = blk_addr_q;
  assign bus.byte_idx    = byte_idx_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.debug       = {2'b00, cmd_q, r1_q, 8'h00, 4'h0, state_q};

endmodule
